// File: rtl/cordic_nco_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cordic_nco_mc                                                   |
// | Purpose  : Time-multiplexed multi-channel CORDIC NCO. One pipelined        |
// |            rotation core serves NCH channels, each with its own phase      |
// |            accumulator, increment and phase offset. Output samples are     |
// |            channel-tagged and valid-qualified.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cordic_nco_mc #(
   parameter int NCH  = 4,              // channels, power of two
   parameter int PW   = 32,             // phase width
   parameter int OW   = 20,             // output sample width
   parameter int ITER = 18,             // micro-rotation stages (ITER <= 27, PW > ITER+4)
   parameter int CW   = $clog2(NCH)     // channel index width
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 sync,
   input  logic                 cfg_we,
   input  logic                 cfg_sel,
   input  logic [CW-1:0]        cfg_ch,
   input  logic [PW-1:0]        cfg_data,
   output logic                 out_valid,
   output logic [CW-1:0]        out_ch,
   output logic signed [OW-1:0] re,
   output logic signed [OW-1:0] im
);

   // Internal datapath width: two fractional guard bits below the output LSB.
   localparam int W  = OW + 2;
   // Kept phase bits: 2 quadrant bits + ITER+2 residue bits; also the z width,
   // with a full circle equal to 2^ZW.
   localparam int ZW = ITER + 4;
   // Phase bits below the kept resolution; they only contribute a carry.
   localparam int LB = PW - ZW;
   localparam int SH = 32 - ZW;

   // Start magnitude pre-divided by the CORDIC gain (1/Kn in Q32, converged value).
   localparam logic [63:0] AMP      = 64'((1 << (OW-1)) - (1 << (OW-6)));
   localparam logic [63:0] INVK_Q32 = 64'd2608131497;
   localparam logic [63:0] X0_64    = (AMP * INVK_Q32 + 64'h8000_0000) >> 32;
   localparam logic signed [W-1:0] X0   = $signed(W'(X0_64 << 2));
   localparam logic signed [W-1:0] MAXV = $signed(W'((1 << (OW-1)) - 1));

   // atan(2^-i) with a full circle of 2^32.
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:  return 32'h2000_0000;
         1:  return 32'h12E4_051E;
         2:  return 32'h09FB_385B;
         3:  return 32'h0511_11D4;
         4:  return 32'h028B_0D43;
         5:  return 32'h0145_D7E1;
         6:  return 32'h00A2_F61E;
         7:  return 32'h0051_7C55;
         8:  return 32'h0028_BE53;
         9:  return 32'h0014_5F2F;
         10: return 32'h000A_2F98;
         11: return 32'h0005_17CC;
         12: return 32'h0002_8BE6;
         13: return 32'h0001_45F3;
         14: return 32'h0000_A2FA;
         15: return 32'h0000_517D;
         16: return 32'h0000_28BE;
         17: return 32'h0000_145F;
         18: return 32'h0000_0A30;
         19: return 32'h0000_0518;
         20: return 32'h0000_028C;
         21: return 32'h0000_0146;
         22: return 32'h0000_00A3;
         23: return 32'h0000_0051;
         24: return 32'h0000_0029;
         25: return 32'h0000_0014;
         26: return 32'h0000_000A;
         default: return 32'h0000_0005;
      endcase
   endfunction

   // Round half away from zero (drop the guard bits), then clamp symmetric.
   function automatic logic signed [OW-1:0] rnd_sat(input logic signed [W-1:0] v);
      logic signed [W-1:0] r;
      r = v[W-1] ? ($signed(v + W'(1)) >>> 2) : ($signed(v + W'(2)) >>> 2);
      if (r > MAXV)
         r = MAXV;
      else if (r < -MAXV)
         r = -MAXV;
      return r[OW-1:0];
   endfunction

   logic [CW-1:0] ch_cnt;
   logic [PW-1:0] acc [0:NCH-1];
   logic [PW-1:0] inc [0:NCH-1];
   logic [PW-1:0] ofs [0:NCH-1];

   logic          ph_v;
   logic [CW-1:0] ph_ch;
   logic [ZW-1:0] ph_p;

   logic                 vs  [0:ITER];
   logic [CW-1:0]        chs [0:ITER];
   logic signed [W-1:0]  xs  [0:ITER];
   logic signed [W-1:0]  ys  [0:ITER];
   logic signed [ZW-1:0] zs  [0:ITER-1];

   // Only the kept upper phase bits are summed; the low field contributes its carry.
   logic          lo_carry;
   logic [ZW-1:0] p_top;
   assign lo_carry = acc[ch_cnt][LB-1:0] > ~ofs[ch_cnt][LB-1:0];
   assign p_top    = acc[ch_cnt][PW-1:LB] + ofs[ch_cnt][PW-1:LB] + ZW'(lo_carry);

   // Sequencer, accumulators, configuration registers and issued-phase register.
   // Config writes land after the issue reads, so a same-cycle write to the
   // issuing channel only takes effect on its next visit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ch_cnt <= '0;
         ph_v   <= 1'b0;
         ph_ch  <= '0;
         ph_p   <= '0;
         for (int c = 0; c < NCH; c++) begin
            acc[c] <= '0;
            inc[c] <= '0;
            ofs[c] <= '0;
         end
      end else begin
         ph_v <= 1'b0;
         if (sync) begin
            ch_cnt <= '0;
            for (int c = 0; c < NCH; c++)
               acc[c] <= '0;
         end else if (enable) begin
            ph_v        <= 1'b1;
            ph_ch       <= ch_cnt;
            ph_p        <= p_top;
            acc[ch_cnt] <= acc[ch_cnt] + inc[ch_cnt];
            ch_cnt      <= ch_cnt + 1'b1;   // NCH = 2^CW, so this wraps naturally
         end
         if (cfg_we) begin
            if (cfg_sel)
               ofs[cfg_ch] <= cfg_data;
            else
               inc[cfg_ch] <= cfg_data;
         end
      end
   end

   // Quadrant pre-rotation: start vector placed on the axis of the selected quadrant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vs[0]  <= 1'b0;
         chs[0] <= '0;
         xs[0]  <= '0;
         ys[0]  <= '0;
         zs[0]  <= '0;
      end else begin
         vs[0]  <= ph_v;
         chs[0] <= ph_ch;
         zs[0]  <= $signed({2'b00, ph_p[ZW-3:0]});
         case (ph_p[ZW-1:ZW-2])
            2'd0:    begin xs[0] <= X0;  ys[0] <= '0;  end
            2'd1:    begin xs[0] <= '0;  ys[0] <= X0;  end
            2'd2:    begin xs[0] <= -X0; ys[0] <= '0;  end
            default: begin xs[0] <= '0;  ys[0] <= -X0; end
         endcase
      end
   end

   for (genvar i = 0; i < ITER; i++) begin : g_rot
      // One micro-rotation, direction chosen to drive the residual angle to zero.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            vs[i+1]  <= 1'b0;
            chs[i+1] <= '0;
            xs[i+1]  <= '0;
            ys[i+1]  <= '0;
         end else begin
            vs[i+1]  <= vs[i];
            chs[i+1] <= chs[i];
            if (!zs[i][ZW-1]) begin
               xs[i+1] <= xs[i] - (ys[i] >>> i);
               ys[i+1] <= ys[i] + (xs[i] >>> i);
            end else begin
               xs[i+1] <= xs[i] + (ys[i] >>> i);
               ys[i+1] <= ys[i] - (xs[i] >>> i);
            end
         end
      end

      if (i < ITER-1) begin : g_z
         localparam logic [63:0]          ATN64 = (64'(atan32(i)) + (64'd1 << (SH-1))) >> SH;
         localparam logic signed [ZW-1:0] ATN   = $signed(ZW'(ATN64));
         // Residual angle update; the last stage needs no residue after it.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
               zs[i+1] <= '0;
            else
               zs[i+1] <= zs[i][ZW-1] ? (zs[i] + ATN) : (zs[i] - ATN);
         end
      end
   end

   // Output register: loads only for valid tokens so samples hold across bubbles.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         re        <= '0;
         im        <= '0;
      end else begin
         out_valid <= vs[ITER];
         if (vs[ITER]) begin
            out_ch <= chs[ITER];
            re     <= rnd_sat(xs[ITER]);
            im     <= rnd_sat(ys[ITER]);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_nco_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cordic_nco_mc                                                |
// | Purpose  : Scoreboard bench for cordic_nco_mc: directed stimulus pushes    |
// |            expected samples, an independent monitor pops and compares.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cordic_nco_mc;

   localparam int LAT = 21;
   localparam int TOL = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic        sync = 1'b0;
   logic        cfg_we = 1'b0;
   logic        cfg_sel = 1'b0;
   logic [1:0]  cfg_ch = 2'd0;
   logic [31:0] cfg_data = 32'd0;
   logic        out_valid;
   logic [1:0]  out_ch;
   logic signed [19:0] re;
   logic signed [19:0] im;

   cordic_nco_mc dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (enable),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_ch   (cfg_ch),
      .cfg_data (cfg_data),
      .out_valid(out_valid),
      .out_ch   (out_ch),
      .re       (re),
      .im       (im)
   );

   always #5 clock = ~clock;

   typedef struct {
      int ch;
      int re;
      int im;
      int edge_n;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Expected (re, im) at the eight 45-degree points, AMP = 507904.
   int tre[8] = '{507904, 359142, 0, -359142, -507904, -359142, 0, 359142};
   int tim[8] = '{0, 359142, 507904, 359142, 0, -359142, -507904, -359142};

   logic [31:0] macc[4];
   logic [31:0] minc[4];
   logic [31:0] mofs[4];
   int          mcnt = 0;

   always @(posedge clock) cyc++;

   // Monitor: every valid sample must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n && out_valid) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_sample ch=%0d re=%0d im=%0d required=none_outstanding",
                     out_ch, re, im);
         end else begin
            exp_t e;
            int dr, di;
            e  = sbq.pop_front();
            dr = int'(re) - e.re;
            di = int'(im) - e.im;
            if (int'(out_ch) != e.ch || dr > TOL || dr < -TOL || di > TOL || di < -TOL ||
                cyc != e.edge_n + LAT - 1) begin
               failures++;
               $display("FAIL sample ch=%0d/%0d re=%0d/%0d im=%0d/%0d edge=%0d/%0d (actual/required)",
                        out_ch, e.ch, re, e.re, im, e.im, cyc, e.edge_n + LAT - 1);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Drive one cycle of inputs and advance the reference accumulator model.
   task automatic drive(input logic en, input logic sy, input logic we,
                        input logic sel, input int ch, input logic [31:0] data);
      logic [31:0] p;
      logic [31:0] q;
      exp_t        e;
      enable = en; sync = sy; cfg_we = we; cfg_sel = sel;
      cfg_ch = 2'(ch); cfg_data = data;
      if (sy) begin
         for (int c = 0; c < 4; c++) macc[c] = 32'd0;
         mcnt = 0;
      end else if (en) begin
         p = macc[mcnt] + mofs[mcnt];
         q = p + 32'h1000_0000;               // nearest 45-degree point
         e.ch = mcnt;
         e.re = tre[q[31:29]];
         e.im = tim[q[31:29]];
         e.edge_n = cyc + 1;
         sbq.push_back(e);
         macc[mcnt] = macc[mcnt] + minc[mcnt];
         mcnt = (mcnt + 1) % 4;
      end
      if (we) begin
         if (sel) mofs[ch] = data;
         else     minc[ch] = data;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
         n++;
      end
      chk("drain_outstanding", sbq.size(), 0);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         macc[c] = 32'd0; minc[c] = 32'd0; mofs[c] = 32'd0;
      end
      mcnt = 0;
      sbq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #1 reset_n = 1'b0;
      #2;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_ch", int'(out_ch), 0);
      chk("reset_re", int'(re), 0);
      chk("reset_im", int'(im), 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Static tones on the four quadrant axes
      drive(0, 0, 1, 1, 1, 32'h4000_0000);
      drive(0, 0, 1, 1, 2, 32'h8000_0000);
      drive(0, 0, 1, 1, 3, 32'hC000_0000);
      repeat (8) drive(1, 0, 0, 0, 0, 32'd0);
      drain();

      // Phase just below full circle maps to about zero degrees
      drive(0, 0, 1, 1, 3, 32'hFFFF_FFFF);
      repeat (4) drive(1, 0, 0, 0, 0, 32'd0);
      drain();

      // Accumulation: channel 2 steps 45 degrees per visit, wrapping the accumulator
      drive(0, 0, 1, 1, 2, 32'h0000_0000);
      drive(0, 0, 1, 0, 2, 32'h2000_0000);
      repeat (40) drive(1, 0, 0, 0, 0, 32'd0);
      drain();

      // Enable gaps: 1,0,0 pattern
      for (int k = 0; k < 24; k++)
         drive((k % 3) == 0, 0, 0, 0, 0, 32'd0);
      drain();

      // Write collision: increment of channel 1 written while channel 1 issues
      while (mcnt != 1) drive(1, 0, 0, 0, 0, 32'd0);
      drive(1, 0, 1, 0, 1, 32'h4000_0000);
      repeat (8) drive(1, 0, 0, 0, 0, 32'd0);
      drain();

      // Sync while channel 3 issues, with a concurrent offset write to channel 0
      while (mcnt != 3) drive(1, 0, 0, 0, 0, 32'd0);
      drive(1, 1, 1, 1, 0, 32'h4000_0000);
      repeat (4) drive(1, 0, 0, 0, 0, 32'd0);
      drain();

      // Reset mid-operation with tokens in flight
      repeat (6) drive(1, 0, 0, 0, 0, 32'd0);
      enable = 1'b0; sync = 1'b0; cfg_we = 1'b0;
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_out_ch", int'(out_ch), 0);
      chk("midreset_re", int'(re), 0);
      chk("midreset_im", int'(im), 0);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;
      repeat (30) drive(0, 0, 0, 0, 0, 32'd0);
      chk("post_reset_idle_valid", int'(out_valid), 0);
      repeat (4) drive(1, 0, 0, 0, 0, 32'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
